// File: rtl/jtopl_mmr_wr_pkg.sv
// Shared definitions for the operator register-write front end:
// group codes, slot count, FSM encoding and the operator address decode.
package jtopl_pkg;

    localparam int SLOTS = 18;

    localparam logic [2:0] GRP_MULT  = 3'd1;
    localparam logic [2:0] GRP_KSLTL = 3'd2;
    localparam logic [2:0] GRP_ARDR  = 3'd3;
    localparam logic [2:0] GRP_SLRR  = 3'd4;
    localparam logic [2:0] GRP_WAV   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [2:0] grp;
        logic [4:0] op;
        logic [7:0] din;
    } wr_req_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] op;
    } op_dec_t;

    // Low address bits are {row[1:0], col[2:0]}; three rows of six operators.
    function automatic op_dec_t op_decode(input logic [4:0] low);
        op_dec_t r;
        r.vld = (low[2:0] <= 3'd5) && (low[4:3] != 2'd3);
        r.op  = {3'd0, low[4:3]} * 5'd6 + {2'd0, low[2:0]};
        return r;
    endfunction

    function automatic logic grp_valid(input logic [2:0] grp, input logic opl2);
        case (grp)
            GRP_MULT, GRP_KSLTL, GRP_ARDR, GRP_SLRR: return 1'b1;
            GRP_WAV: return opl2;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtopl_mmr_wr_edge.sv
// CPU write-event detector: one event per low pulse of wr_n while selected,
// split into address-port and data-port events with the bus data alongside.
module jtopl_wr_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_din,
    output logic       addr_ev,
    output logic       data_ev,
    output logic [7:0] ev_din
);

    logic wr_n_q;
    logic ev;

    always_ff @(posedge clk) begin
        if (!rst) wr_n_q <= 1'b1;
        else      wr_n_q <= cpu_wr_n;
    end

    // Falling edge of wr_n qualified by chip select; independent of cen.
    assign ev      = !cpu_cs_n && !cpu_wr_n && wr_n_q;
    assign addr_ev = ev && !cpu_a0;
    assign data_ev = ev &&  cpu_a0;
    assign ev_din  = cpu_din;

endmodule

// File: rtl/jtopl_mmr_wr.sv
// Operator register-write front end: latches one pending operator write and
// replays it as din/up_*/update_op_* strobes when its slot comes round.
module jtopl_mmr_wr #(
    parameter int SLOTS = 18,
    parameter bit OPL2  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] cpu_din,
    input  logic       cpu_a0,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    output logic       busy,
    output logic       overrun,
    output logic [4:0] slot,
    output logic [7:0] din,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV
);

    import jtopl_pkg::wr_state_t, jtopl_pkg::IDLE, jtopl_pkg::WAIT, jtopl_pkg::DRIVE,
           jtopl_pkg::wr_req_t, jtopl_pkg::op_dec_t, jtopl_pkg::op_decode,
           jtopl_pkg::grp_valid, jtopl_pkg::GRP_MULT, jtopl_pkg::GRP_KSLTL,
           jtopl_pkg::GRP_ARDR, jtopl_pkg::GRP_SLRR, jtopl_pkg::GRP_WAV;

    logic       addr_ev, data_ev;
    logic [7:0] ev_din;
    logic [7:0] addr;
    wr_state_t  st, st_nx;
    wr_req_t    req;
    logic [1:0] phase, phase_nx;
    op_dec_t    dec;
    logic       wr_ok, accept, match, win;

    jtopl_wr_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .cpu_cs_n (cpu_cs_n),
        .cpu_wr_n (cpu_wr_n),
        .cpu_a0   (cpu_a0),
        .cpu_din  (cpu_din),
        .addr_ev  (addr_ev),
        .data_ev  (data_ev),
        .ev_din   (ev_din)
    );

    assign dec   = op_decode(addr[4:0]);
    assign wr_ok = data_ev && dec.vld && grp_valid(addr[7:5], OPL2);
    assign match = (slot == req.op);

    always_comb begin
        st_nx    = st;
        phase_nx = phase;
        accept   = 1'b0;
        case (st)
            IDLE: begin
                if (wr_ok) begin
                    st_nx  = WAIT;
                    accept = 1'b1;
                end
            end
            // Phase 0 is the matching cen period itself, so DRIVE starts at 1.
            WAIT: begin
                if (cen && match) begin
                    st_nx    = DRIVE;
                    phase_nx = 2'd1;
                end
            end
            DRIVE: begin
                if (cen) begin
                    if (phase == 2'd3) st_nx = IDLE;
                    else               phase_nx = phase + 2'd1;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st      <= IDLE;
            phase   <= 2'd0;
            slot    <= 5'd0;
            addr    <= 8'd0;
            req     <= '0;
            overrun <= 1'b0;
        end else begin
            st    <= st_nx;
            phase <= phase_nx;
            if (cen) slot <= (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
            if (addr_ev) addr <= ev_din;
            if (accept) begin
                req.grp <= addr[7:5];
                req.op  <= dec.op;
                req.din <= ev_din;
            end
            if (wr_ok && st != IDLE) overrun <= 1'b1;
        end
    end

    // Strobes come only from registered state, so they hold between cen pulses.
    assign update_op_I  = (st == WAIT) && match;
    assign update_op_II = (st == DRIVE) && (phase == 2'd1);
    assign update_op_IV = (st == DRIVE) && (phase == 2'd3);
    assign win          = update_op_I || (st == DRIVE);

    assign busy      = (st != IDLE);
    assign din       = req.din;
    assign up_mult   = win && (req.grp == GRP_MULT);
    assign up_ksl_tl = win && (req.grp == GRP_KSLTL);
    assign up_ar_dr  = win && (req.grp == GRP_ARDR);
    assign up_sl_rr  = win && (req.grp == GRP_SLRR);
    assign up_wav    = win && (req.grp == GRP_WAV);

endmodule

// File: tb/tb_jtopl_mmr_wr.sv
// Bench for jtopl_mmr_wr: cen-count timeline model checked every cycle, plus
// directed writes with literal slot/data expectations.
module tb_jtopl_mmr_wr;

    logic       clk = 1'b0, rst = 1'b0, cen = 1'b0;
    logic [7:0] cpu_din = 8'd0;
    logic       cpu_a0 = 1'b0, cpu_cs_n = 1'b1, cpu_wr_n = 1'b1;

    logic       busy, overrun, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       upd_I, upd_II, upd_IV;
    logic [4:0] slot;
    logic [7:0] din;

    logic       b_busy, b_overrun, b_mult, b_ksl, b_ardr, b_slrr, b_wav, b_I, b_II, b_IV;
    logic [4:0] b_slot;
    logic [7:0] b_din;

    jtopl_mmr_wr #(.SLOTS(18), .OPL2(1'b1)) u0 (
        .clk(clk), .rst(rst), .cen(cen), .cpu_din(cpu_din), .cpu_a0(cpu_a0),
        .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .busy(busy), .overrun(overrun),
        .slot(slot), .din(din), .up_mult(up_mult), .up_ksl_tl(up_ksl_tl),
        .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr), .up_wav(up_wav),
        .update_op_I(upd_I), .update_op_II(upd_II), .update_op_IV(upd_IV)
    );

    jtopl_mmr_wr #(.SLOTS(18), .OPL2(1'b0)) u1 (
        .clk(clk), .rst(rst), .cen(cen), .cpu_din(cpu_din), .cpu_a0(cpu_a0),
        .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .busy(b_busy), .overrun(b_overrun),
        .slot(b_slot), .din(b_din), .up_mult(b_mult), .up_ksl_tl(b_ksl),
        .up_ar_dr(b_ardr), .up_sl_rr(b_slrr), .up_wav(b_wav),
        .update_op_I(b_I), .update_op_II(b_II), .update_op_IV(b_IV)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit cen_half = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a pending write's strobes live at absolute cen-period indices
    // p, p+1, p+3 where p is the first eligible period whose slot is the target.
    bit         started = 1'b0, m_pend = 1'b0, m_ovr = 1'b0, m_wrp = 1'b1, m_ev;
    logic [7:0] m_addr = 8'd0, m_din = 8'd0;
    logic [2:0] m_grp = 3'd0;
    int         m_ncen = 0, m_p = 0, m_tgt, m_p0;

    function automatic bit m_decode(input logic [7:0] a, output int op);
        int g, lo;
        g  = int'(a) / 32;
        lo = int'(a) % 32;
        op = (lo / 8) * 6 + lo % 8;
        return (g == 1 || g == 2 || g == 3 || g == 4 || g == 7) && (lo / 8 < 3) && (lo % 8 < 6);
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst) begin
            m_ncen = 0; m_pend = 1'b0; m_ovr = 1'b0; m_wrp = 1'b1; m_addr = 8'd0;
        end else begin
            m_ev = !cpu_cs_n && !cpu_wr_n && m_wrp;
            if (m_ev && !cpu_a0) m_addr = cpu_din;
            if (m_ev && cpu_a0 && m_decode(m_addr, m_tgt)) begin
                if (m_pend) m_ovr = 1'b1;
                else begin
                    m_pend = 1'b1;
                    m_grp  = m_addr[7:5];
                    m_din  = cpu_din;
                    m_p0   = m_ncen + (cen ? 1 : 0);
                    m_p    = m_p0 + ((m_tgt - m_p0 % 18 + 18) % 18);
                end
            end
            if (cen) m_ncen++;
            if (m_pend && m_ncen >= m_p + 4) m_pend = 1'b0;
            m_wrp = cpu_wr_n;
        end
    end

    bit         c_win;
    logic [4:0] c_up;

    always @(negedge clk) begin
        if (started) begin
            c_win = m_pend && m_ncen >= m_p && m_ncen <= m_p + 3;
            c_up  = c_win ? {m_grp == 3'd1, m_grp == 3'd2, m_grp == 3'd3, m_grp == 3'd4, m_grp == 3'd7}
                          : 5'd0;
            chk("cmp slot", slot, m_ncen % 18);
            chk("cmp busy", busy, m_pend);
            chk("cmp overrun", overrun, m_ovr);
            chk("cmp update_op_I", upd_I, c_win && m_ncen == m_p);
            chk("cmp update_op_II", upd_II, c_win && m_ncen == m_p + 1);
            chk("cmp update_op_IV", upd_IV, c_win && m_ncen == m_p + 3);
            chk("cmp up_vec", {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, c_up);
            if (c_win) chk("cmp din", din, m_din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cen = cen_half ? ~cen : 1'b1;
    endtask

    task automatic cpu_wr(input logic a0, input logic [7:0] d);
        cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_a0 = a0; cpu_din = d;
        tick();
        cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0: return upd_I;
            1: return upd_II;
            2: return upd_IV;
            3: return !busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input string nm, output int k);
        k = 0;
        while (!sel(w) && k < 80) begin tick(); k++; end
        chk({nm, " reached"}, k < 80, 1);
    endtask

    task automatic wait_slot(input int s);
        int k = 0;
        while (slot !== 5'(s) && k < 80) begin tick(); k++; end
        chk("slot sync reached", k < 80, 1);
    endtask

    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] d,
                          input int si, input logic [4:0] upv, input bit chk_b);
        int k;
        wait_slot((si + 7) % 18);
        cpu_wr(1'b0, a); tick(); cpu_wr(1'b1, d);
        chk({nm, " busy after write"}, busy, 1);
        if (chk_b) chk({nm, " opl2=0 busy"}, b_busy, 0);
        wait_for(0, {nm, " I"}, k);
        chk({nm, " I slot"}, slot, si);
        chk({nm, " I up"}, {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, upv);
        chk({nm, " I din"}, din, d);
        wait_for(1, {nm, " II"}, k);
        chk({nm, " II slot"}, slot, (si + 1) % 18);
        wait_for(2, {nm, " IV"}, k);
        chk({nm, " IV slot"}, slot, (si + 3) % 18);
        chk({nm, " IV din"}, din, d);
        wait_for(3, {nm, " idle"}, k);
        chk({nm, " idle slot"}, slot, (si + 4) % 18);
        chk({nm, " idle up"}, {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 0);
    endtask

    initial begin
        int k, cnt;
        repeat (3) tick();
        chk("reset slot", slot, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        chk("reset din", din, 0);
        chk("reset strobes", {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, upd_I, upd_II, upd_IV}, 0);

        rst = 1'b1; cen_half = 1'b0; cen = 1'b1;
        repeat (17) tick();
        chk("slot count 17", slot, 17);
        tick();
        chk("slot wrap 0", slot, 0);

        run_op("mult", 8'h20, 8'h81, 0, 5'b10000, 1'b0);

        // write landing on the target's own slot waits a full revolution
        wait_slot(3);
        cpu_wr(1'b0, 8'h25); tick(); cpu_wr(1'b1, 8'h66);
        wait_for(0, "lat same", k);
        chk("latency same-slot", k, 17);
        wait_for(3, "lat same idle", k);
        // target on the very next cen qualifies immediately
        wait_slot(2);
        cpu_wr(1'b0, 8'h25); tick(); cpu_wr(1'b1, 8'h67);
        wait_for(0, "lat next", k);
        chk("latency next-cen", k, 0);
        wait_for(3, "lat next idle", k);

        run_op("ksl_tl", 8'h4D, 8'h3F, 11, 5'b01000, 1'b0);

        cen_half = 1'b1;
        run_op("wrap", 8'h95, 8'hA5, 17, 5'b00010, 1'b0);
        cen_half = 1'b0;

        cpu_wr(1'b0, 8'h26); tick(); cpu_wr(1'b1, 8'h5A); tick();
        chk("invalid col busy", busy, 0);
        cpu_wr(1'b0, 8'h38); tick(); cpu_wr(1'b1, 8'h5B); tick();
        chk("invalid row busy", busy, 0);
        cpu_wr(1'b0, 8'hB0); tick(); cpu_wr(1'b1, 8'h5C); tick();
        chk("invalid grp busy", busy, 0);
        repeat (20) tick();
        chk("invalid overrun", overrun, 0);

        wait_slot(7);
        cpu_wr(1'b0, 8'h20); tick(); cpu_wr(1'b1, 8'h11); tick();
        chk("ovr first busy", busy, 1);
        chk("ovr before", overrun, 0);
        cpu_wr(1'b0, 8'h40); tick(); cpu_wr(1'b1, 8'h22); tick();
        chk("ovr set", overrun, 1);
        wait_for(0, "ovr I", k);
        chk("ovr I slot", slot, 0);
        chk("ovr I up", {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 5'b10000);
        chk("ovr I din", din, 8'h11);
        wait_for(3, "ovr idle", k);

        run_op("wav", 8'hE3, 8'h02, 3, 5'b00001, 1'b1);

        wait_slot(0);
        cpu_wr(1'b0, 8'h35); tick(); cpu_wr(1'b1, 8'h44);
        chk("rst-wait busy", busy, 1);
        rst = 1'b0; tick(); tick();
        chk("rst-wait cleared", busy, 0);
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin tick(); if (upd_I || upd_II || upd_IV) cnt++; end
        chk("rst-wait no strobes", cnt, 0);
        chk("rst-wait overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
